// File: rtl/ps2_key_event_decoder.sv
// ps2_key_event_decoder
// Folds the raw PS/2 set-2 byte stream (E0/F0 prefixes, E1 pause sequence,
// controller replies) into single {ext, brk, code} key events, filters
// typematic repeats of the held key, and buffers events in a small
// first-word-fall-through FIFO so consumers pop one event per keystroke.
module ps2_key_event_decoder #(
    parameter int DEPTH_LOG2      = 2,
    parameter bit SUPPRESS_REPEAT = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_byte,
    input  logic       rx_valid,
    input  logic       rd_en,
    input  logic       clr_ovf,
    output logic [7:0] ev_code,
    output logic       ev_ext,
    output logic       ev_break,
    output logic       ev_valid,
    output logic       fifo_full,
    output logic       overflow,
    output logic       held_valid,
    output logic [7:0] held_code,
    output logic       held_ext
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_C = (DEPTH_LOG2+1)'(DEPTH);
    localparam logic [DEPTH_LOG2:0]   CNT_ONE = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2:0]   CNT_ZERO = (DEPTH_LOG2+1)'(0);
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE = DEPTH_LOG2'(1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_EXT    = 3'd1,
        ST_BRK    = 3'd2,
        ST_EXTBRK = 3'd3,
        ST_PAUSE  = 3'd4
    } state_t;

    // Bytes the keyboard sends to signal a transmission or internal error.
    function automatic logic is_err_byte(input logic [7:0] b);
        return (b == 8'h00) || (b == 8'hFF) || (b == 8'hFE) || (b == 8'hFC);
    endfunction

    // Controller replies (ACK, BAT pass, echo) that never form a key event.
    function automatic logic is_reply_byte(input logic [7:0] b);
        return (b == 8'hFA) || (b == 8'hAA) || (b == 8'hEE);
    endfunction

    state_t     state_q, state_d;
    logic [2:0] pause_cnt_q, pause_cnt_d;

    logic       emit_s;
    logic       em_ext_s;
    logic       em_brk_s;
    logic [7:0] em_code_s;

    logic       held_valid_q;
    logic [7:0] held_code_q;
    logic       held_ext_q;

    logic [9:0]            mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q;
    logic [DEPTH_LOG2-1:0] rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  ovf_q;

    logic       match_s;
    logic       push_s;
    logic       pop_s;
    logic       full_s;
    logic       empty_s;
    logic       wr_en_s;
    logic       ovf_set_s;
    logic [9:0] head_s;

    // Prefix FSM decode: next state, pause counter and the emitted event.
    always_comb begin
        state_d     = state_q;
        pause_cnt_d = pause_cnt_q;
        emit_s      = 1'b0;
        em_ext_s    = 1'b0;
        em_brk_s    = 1'b0;
        em_code_s   = rx_byte;
        if (rx_valid) begin
            case (state_q)
                ST_IDLE: begin
                    if (rx_byte == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (rx_byte == 8'hF0) begin
                        state_d = ST_BRK;
                    end else if (rx_byte == 8'hE1) begin
                        state_d     = ST_PAUSE;
                        pause_cnt_d = 3'd7;
                    end else if (is_reply_byte(rx_byte) || is_err_byte(rx_byte)) begin
                        state_d = ST_IDLE;
                    end else begin
                        emit_s = 1'b1;
                    end
                end
                ST_EXT: begin
                    if (rx_byte == 8'hF0) begin
                        state_d = ST_EXTBRK;
                    end else if (rx_byte == 8'hE0) begin
                        state_d = ST_EXT;
                    end else if (is_err_byte(rx_byte)) begin
                        state_d = ST_IDLE;
                    end else begin
                        emit_s   = 1'b1;
                        em_ext_s = 1'b1;
                        state_d  = ST_IDLE;
                    end
                end
                ST_BRK: begin
                    state_d = ST_IDLE;
                    if (!is_err_byte(rx_byte)) begin
                        emit_s   = 1'b1;
                        em_brk_s = 1'b1;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                ST_EXTBRK: begin
                    state_d = ST_IDLE;
                    if (!is_err_byte(rx_byte)) begin
                        emit_s   = 1'b1;
                        em_ext_s = 1'b1;
                        em_brk_s = 1'b1;
                    end else begin
                        emit_s = 1'b0;
                    end
                end
                ST_PAUSE: begin
                    // The last byte of the 8-byte pause sequence stands for the Pause key.
                    if (pause_cnt_q == 3'd1) begin
                        emit_s      = 1'b1;
                        em_ext_s    = 1'b1;
                        em_code_s   = 8'h77;
                        pause_cnt_d = 3'd0;
                        state_d     = ST_IDLE;
                    end else if (pause_cnt_q == 3'd0) begin
                        state_d = ST_IDLE;
                    end else begin
                        pause_cnt_d = pause_cnt_q - 3'd1;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    pause_cnt_d = 3'd0;
                end
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Held-key filter and FIFO push/pop arbitration.
    always_comb begin
        match_s   = held_valid_q && (em_ext_s == held_ext_q) && (em_code_s == held_code_q);
        full_s    = (count_q == DEPTH_C);
        empty_s   = (count_q == CNT_ZERO);
        if (!em_brk_s && SUPPRESS_REPEAT && match_s) begin
            push_s = 1'b0;
        end else begin
            push_s = emit_s;
        end
        pop_s     = rd_en && !empty_s;
        wr_en_s   = push_s && (!full_s || pop_s);
        ovf_set_s = push_s && full_s && !pop_s;
        head_s    = mem_q[rd_ptr_q];
    end

    // State, held key, FIFO storage, pointers, count and sticky overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            pause_cnt_q  <= 3'd0;
            held_valid_q <= 1'b0;
            held_code_q  <= 8'h00;
            held_ext_q   <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            ovf_q        <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 10'h000;
            end
        end else begin
            state_q     <= state_d;
            pause_cnt_q <= pause_cnt_d;

            if (push_s) begin
                if (!em_brk_s) begin
                    held_valid_q <= 1'b1;
                    held_code_q  <= em_code_s;
                    held_ext_q   <= em_ext_s;
                end else if (match_s) begin
                    held_valid_q <= 1'b0;
                end
            end

            if (wr_en_s) begin
                mem_q[wr_ptr_q] <= {em_ext_s, em_brk_s, em_code_s};
                wr_ptr_q        <= wr_ptr_q + PTR_ONE;
            end
            if (pop_s) begin
                rd_ptr_q <= rd_ptr_q + PTR_ONE;
            end

            case ({wr_en_s, pop_s})
                2'b10:   count_q <= count_q + CNT_ONE;
                2'b01:   count_q <= count_q - CNT_ONE;
                default: count_q <= count_q;
            endcase

            // A new overflow takes priority over a coincident clear.
            if (ovf_set_s) begin
                ovf_q <= 1'b1;
            end else if (clr_ovf) begin
                ovf_q <= 1'b0;
            end
        end
    end

    assign ev_valid   = !empty_s;
    assign ev_code    = empty_s ? 8'h00 : head_s[7:0];
    assign ev_break   = empty_s ? 1'b0  : head_s[8];
    assign ev_ext     = empty_s ? 1'b0  : head_s[9];
    assign fifo_full  = full_s;
    assign overflow   = ovf_q;
    assign held_valid = held_valid_q;
    assign held_code  = held_code_q;
    assign held_ext   = held_ext_q;

endmodule

// File: tb/tb_ps2_key_event_decoder.sv
// Directed testbench for ps2_key_event_decoder.
module tb_ps2_key_event_decoder;

    logic       clk;
    logic       reset;
    logic [7:0] rx_byte;
    logic       rx_valid;
    logic       rd_en;
    logic       clr_ovf;
    logic [7:0] ev_code;
    logic       ev_ext;
    logic       ev_break;
    logic       ev_valid;
    logic       fifo_full;
    logic       overflow;
    logic       held_valid;
    logic [7:0] held_code;
    logic       held_ext;

    int pass_cnt;
    int total_cnt;

    ps2_key_event_decoder #(.DEPTH_LOG2(2), .SUPPRESS_REPEAT(1'b1)) dut (
        .clk        (clk),
        .reset      (reset),
        .rx_byte    (rx_byte),
        .rx_valid   (rx_valid),
        .rd_en      (rd_en),
        .clr_ovf    (clr_ovf),
        .ev_code    (ev_code),
        .ev_ext     (ev_ext),
        .ev_break   (ev_break),
        .ev_valid   (ev_valid),
        .fifo_full  (fifo_full),
        .overflow   (overflow),
        .held_valid (held_valid),
        .held_code  (held_code),
        .held_ext   (held_ext)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; rx_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0; rx_byte = 8'h00;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_byte = b; rx_valid = 1'b1;
        tick();
        rx_valid = 1'b0;
    endtask

    task automatic pop();
        rd_en = 1'b1;
        tick();
        rd_en = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL rst_ev_valid got %b want 0", ev_valid); else pass_cnt++;
        total_cnt++; if ({ev_ext, ev_break, ev_code} !== 10'h000) $display("FAIL rst_head got %h want 000", {ev_ext, ev_break, ev_code}); else pass_cnt++;
        total_cnt++; if ({fifo_full, overflow, held_valid, held_ext} !== 4'b0000) $display("FAIL rst_flags got %b want 0000", {fifo_full, overflow, held_valid, held_ext}); else pass_cnt++;
        total_cnt++; if (held_code !== 8'h00) $display("FAIL rst_held_code got %h want 00", held_code); else pass_cnt++;
    endtask

    task automatic test_single_make();
        do_reset();
        send_byte(8'h1C);
        total_cnt++; if (ev_valid !== 1'b1) $display("FAIL t1_ev_valid got %b want 1", ev_valid); else pass_cnt++;
        total_cnt++; if ({ev_ext, ev_break, ev_code} !== {1'b0, 1'b0, 8'h1C}) $display("FAIL t1_head got %h want 01c", {ev_ext, ev_break, ev_code}); else pass_cnt++;
        total_cnt++; if ({held_valid, held_ext, held_code} !== {1'b1, 1'b0, 8'h1C}) $display("FAIL t1_held got %h want 21c", {held_valid, held_ext, held_code}); else pass_cnt++;
    endtask

    task automatic test_repeat_suppress();
        do_reset();
        send_byte(8'h1C); send_byte(8'h1C); send_byte(8'h1C);
        send_byte(8'hF0); send_byte(8'h1C);
        total_cnt++; if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) $display("FAIL t2_first got %h want 41c", {ev_valid, ev_ext, ev_break, ev_code}); else pass_cnt++;
        pop();
        total_cnt++; if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b1, 8'h1C}) $display("FAIL t2_second got %h want 51c", {ev_valid, ev_ext, ev_break, ev_code}); else pass_cnt++;
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL t2_empty got %b want 0", ev_valid); else pass_cnt++;
        total_cnt++; if (held_valid !== 1'b0) $display("FAIL t2_held_valid got %b want 0", held_valid); else pass_cnt++;
    endtask

    task automatic test_extended();
        do_reset();
        send_byte(8'hE0); send_byte(8'h75);
        total_cnt++; if ({held_valid, held_ext, held_code} !== {1'b1, 1'b1, 8'h75}) $display("FAIL t3_held got %h want 375", {held_valid, held_ext, held_code}); else pass_cnt++;
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h75);
        total_cnt++; if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b1, 1'b0, 8'h75}) $display("FAIL t3_make got %h want 675", {ev_valid, ev_ext, ev_break, ev_code}); else pass_cnt++;
        pop();
        total_cnt++; if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b1, 1'b1, 8'h75}) $display("FAIL t3_break got %h want 775", {ev_valid, ev_ext, ev_break, ev_code}); else pass_cnt++;
        pop();
        total_cnt++; if ({ev_valid, held_valid} !== 2'b00) $display("FAIL t3_after got %b want 00", {ev_valid, held_valid}); else pass_cnt++;
    endtask

    task automatic test_pause();
        logic [7:0] seq [8];
        seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        do_reset();
        for (int i = 0; i < 7; i++) send_byte(seq[i]);
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL t4_mid got %b want 0", ev_valid); else pass_cnt++;
        send_byte(seq[7]);
        total_cnt++; if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b1, 1'b0, 8'h77}) $display("FAIL t4_pause got %h want 677", {ev_valid, ev_ext, ev_break, ev_code}); else pass_cnt++;
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL t4_single got %b want 0", ev_valid); else pass_cnt++;
        send_byte(8'h1C);
        total_cnt++; if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) $display("FAIL t4_idle got %h want 41c", {ev_valid, ev_ext, ev_break, ev_code}); else pass_cnt++;
    endtask

    task automatic test_overflow();
        logic [7:0] drain [4];
        drain = '{8'h1D, 8'h24, 8'h2D, 8'h35};
        do_reset();
        send_byte(8'h15); send_byte(8'h1D); send_byte(8'h24); send_byte(8'h2D);
        total_cnt++; if ({fifo_full, overflow} !== 2'b10) $display("FAIL t5_full got %b want 10", {fifo_full, overflow}); else pass_cnt++;
        send_byte(8'h2C);
        total_cnt++; if ({fifo_full, overflow} !== 2'b11) $display("FAIL t5_ovf got %b want 11", {fifo_full, overflow}); else pass_cnt++;
        total_cnt++; if (ev_code !== 8'h15) $display("FAIL t5_head got %h want 15", ev_code); else pass_cnt++;
        // pop and push together while full
        rx_byte = 8'h35; rx_valid = 1'b1; rd_en = 1'b1;
        tick();
        rx_valid = 1'b0; rd_en = 1'b0;
        total_cnt++; if ({fifo_full, overflow} !== 2'b11) $display("FAIL t5_pushpop got %b want 11", {fifo_full, overflow}); else pass_cnt++;
        total_cnt++; if (ev_code !== 8'h1D) $display("FAIL t5_pushpop_head got %h want 1d", ev_code); else pass_cnt++;
        clr_ovf = 1'b1;
        tick();
        clr_ovf = 1'b0;
        total_cnt++; if (overflow !== 1'b0) $display("FAIL t5_clr got %b want 0", overflow); else pass_cnt++;
        // new overflow coincident with clear: set wins
        rx_byte = 8'h3C; rx_valid = 1'b1; clr_ovf = 1'b1;
        tick();
        rx_valid = 1'b0; clr_ovf = 1'b0;
        total_cnt++; if (overflow !== 1'b1) $display("FAIL t5_set_wins got %b want 1", overflow); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            total_cnt++; if ({ev_valid, ev_code} !== {1'b1, drain[i]}) $display("FAIL t5_drain%0d got %h want %h", i, {ev_valid, ev_code}, {1'b1, drain[i]}); else pass_cnt++;
            pop();
        end
        total_cnt++; if ({ev_valid, fifo_full} !== 2'b00) $display("FAIL t5_empty got %b want 00", {ev_valid, fifo_full}); else pass_cnt++;
        pop();
        pop();
        send_byte(8'h1B);
        total_cnt++; if ({ev_valid, ev_code} !== {1'b1, 8'h1B}) $display("FAIL t5_empty_rd got %h want 11b", {ev_valid, ev_code}); else pass_cnt++;
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL t5_final got %b want 0", ev_valid); else pass_cnt++;
    endtask

    task automatic test_reset_midseq();
        do_reset();
        send_byte(8'hE0); send_byte(8'hF0);
        reset = 1'b1; tick(); reset = 1'b0;
        send_byte(8'h1C);
        total_cnt++; if ({ev_valid, ev_ext, ev_break, ev_code} !== {1'b1, 1'b0, 1'b0, 8'h1C}) $display("FAIL t6_after_rst got %h want 41c", {ev_valid, ev_ext, ev_break, ev_code}); else pass_cnt++;
        pop();
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL t6_one got %b want 0", ev_valid); else pass_cnt++;
        send_byte(8'hFA); send_byte(8'hAA); send_byte(8'hFE); send_byte(8'h00);
        total_cnt++; if (ev_valid !== 1'b0) $display("FAIL t6_replies got %b want 0", ev_valid); else pass_cnt++;
        // reset inside a pause sequence
        send_byte(8'hE1); send_byte(8'h14);
        reset = 1'b1; tick(); reset = 1'b0;
        send_byte(8'h2D);
        total_cnt++; if ({ev_valid, ev_ext, ev_code} !== {1'b1, 1'b0, 8'h2D}) $display("FAIL t6_pause_rst got %h want 22d", {ev_valid, ev_ext, ev_code}); else pass_cnt++;
        // byte strobed during reset is ignored
        reset = 1'b1; rx_byte = 8'h1C; rx_valid = 1'b1;
        tick();
        reset = 1'b0; rx_valid = 1'b0;
        tick();
        total_cnt++; if ({ev_valid, held_valid} !== 2'b00) $display("FAIL t6_rx_in_rst got %b want 00", {ev_valid, held_valid}); else pass_cnt++;
    endtask

    initial begin
        pass_cnt  = 0;
        total_cnt = 0;
        reset = 1'b1; rx_byte = 8'h00; rx_valid = 1'b0; rd_en = 1'b0; clr_ovf = 1'b0;
        test_reset();
        test_single_make();
        test_repeat_suppress();
        test_extended();
        test_pause();
        test_overflow();
        test_reset_midseq();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
